// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - segmented-carry pipelined adder/subtractor with valid/ready and flags
// Optional saturation on signed overflow: define ADDSUB_SAT_EN.
module pipelined_addsub #(
    parameter int WIDTH = 8,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int NSTG = WIDTH / SEG;
    localparam int NREG = (NSTG > 1) ? NSTG - 1 : 1;
    localparam int L    = NSTG - 1;

    // vr[L] is the output slot; vr[0..L-1] track the intermediate stages
    logic [NSTG-1:0]  vr;
    logic [NSTG-1:0]  v_in;
    logic             advance;

    logic [WIDTH-1:0] xr [NREG];
    logic [WIDTH-1:0] br [NREG];
    logic [WIDTH-1:0] sr [NREG];
    logic             cr [NREG];

    logic [WIDTH-1:0] xn [NSTG];
    logic [WIDTH-1:0] bn [NSTG];
    logic [WIDTH-1:0] sn [NSTG];
    logic             cn [NSTG];

    logic [WIDTH-1:0] xi, bi, si;
    logic             ci;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             c_msb;
    logic             ovf_fin;
    logic [WIDTH-1:0] s_fin;

    assign b_eff     = sub ? ~Y : Y;
    assign c0        = sub | cin;
    assign advance   = ~vr[L] | out_ready;
    assign in_ready  = advance;
    assign out_valid = vr[L];

    always_comb begin
        v_in[0] = in_valid;
        for (int k = 1; k < NSTG; k++) begin
            v_in[k] = vr[k-1];
        end
    end

    // Each stage resolves one SEG-wide slice, rippling the carry from the stage before
    always_comb begin
        xi      = '0;
        bi      = '0;
        si      = '0;
        ci      = 1'b0;
        seg_sum = '0;
        for (int k = 0; k < NSTG; k++) begin
            xi      = (k == 0) ? X     : xr[(k == 0) ? 0 : k - 1];
            bi      = (k == 0) ? b_eff : br[(k == 0) ? 0 : k - 1];
            si      = (k == 0) ? '0    : sr[(k == 0) ? 0 : k - 1];
            ci      = (k == 0) ? c0    : cr[(k == 0) ? 0 : k - 1];
            seg_sum = {1'b0, xi[k*SEG +: SEG]} + {1'b0, bi[k*SEG +: SEG]} + {{SEG{1'b0}}, ci};
            xn[k]   = xi;
            bn[k]   = bi;
            sn[k]   = si;
            sn[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
            cn[k]   = seg_sum[SEG];
        end
    end

    // Carry into the MSB is recovered from the MSB's own sum bit
    always_comb begin
        c_msb   = xn[L][WIDTH-1] ^ bn[L][WIDTH-1] ^ sn[L][WIDTH-1];
        ovf_fin = c_msb ^ cn[L];
`ifdef ADDSUB_SAT_EN
        if (ovf_fin) begin
            s_fin = xn[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            s_fin = sn[L];
        end
`else
        s_fin = sn[L];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vr   <= '0;
            S    <= '0;
            Co   <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
            for (int k = 0; k < NREG; k++) begin
                xr[k] <= '0;
                br[k] <= '0;
                sr[k] <= '0;
                cr[k] <= 1'b0;
            end
        end else if (advance) begin
            vr <= v_in;
            // Data only loads behind a valid slot so bubbles leave registers untouched
            for (int k = 0; k < NSTG - 1; k++) begin
                if (v_in[k]) begin
                    xr[k] <= xn[k];
                    br[k] <= bn[k];
                    sr[k] <= sn[k];
                    cr[k] <= cn[k];
                end
            end
            if (v_in[L]) begin
                S    <= s_fin;
                Co   <= cn[L];
                ovf  <= ovf_fin;
                zero <= ~|s_fin;
                neg  <= s_fin[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - vector table, stall/reset sequences and random scoreboard for pipelined_addsub
module tb_pipelined_addsub;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] X, Y;
    logic       cin, sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] S;
    logic       Co, ovf, zero, neg;

    pipelined_addsub #(.WIDTH(8), .SEG(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Co(Co), .ovf(ovf), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    logic [11:0] exp_q[$];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_s = '0;

    typedef struct {
        logic [7:0] x, y;
        logic       c, s;
        logic [7:0] es;
        logic       eco, eovf, ez, en;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer arithmetic on the unsigned and signed interpretations
    function automatic logic [11:0] model(input logic [7:0] x, y, input logic c, s);
        int ux, uy, ax, ay, us, ss, r;
        logic co, ov;
        ux = x; uy = y;
        ax = $signed(x); ay = $signed(y);
        if (s) begin
            us = ux - uy; co = (ux >= uy); ss = ax - ay;
        end else begin
            us = ux + uy + c; co = (us > 255); ss = ax + ay + c;
        end
        r  = us & 255;
        ov = (ss > 127) || (ss < -128);
`ifdef ADDSUB_SAT_EN
        if (ov) r = (ss > 127) ? 127 : 128;
`endif
        return {r[7:0], co, ov, (r == 0), (r >= 128)};
    endfunction

    task automatic step(input bit iv, input logic [7:0] x, input logic [7:0] y,
                        input bit c, input bit s, input bit ordy);
        logic [11:0] e;
        in_valid = iv; X = x; Y = y; cin = c; sub = s; out_ready = ordy;
        #1;
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_s", S, prev_s);
        end
        prev_stall = out_valid && !out_ready;
        prev_s     = S;
        if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_out: got %0h expected none", {S, Co, ovf, zero, neg});
            end else begin
                e = exp_q.pop_front();
                check("stream_out", {S, Co, ovf, zero, neg}, e);
                n_out++;
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(x, y, c, s));
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];
    int   lat;
    int   out_before;

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h07, 8'h07, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
`endif

        rst = 1'b1; in_valid = 1'b0; X = '0; Y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        check("rst_out_valid", out_valid, 0);
        check("rst_s", S, 0);
        check("rst_flags", {Co, ovf, zero, neg}, 0);
        rst = 1'b0;
        cyc();
        check("idle_in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            X = vecs[i].x; Y = vecs[i].y; cin = vecs[i].c; sub = vecs[i].s;
            in_valid = 1'b1; out_ready = 1'b1;
            cyc();
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 8) begin
                cyc();
                lat++;
            end
            check($sformatf("vec%0d_latency", i), lat, 1);
            check($sformatf("vec%0d_s", i), S, vecs[i].es);
            check($sformatf("vec%0d_co", i), Co, vecs[i].eco);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].eovf);
            check($sformatf("vec%0d_zero", i), zero, vecs[i].ez);
            check($sformatf("vec%0d_neg", i), neg, vecs[i].en);
            cyc();
        end

        out_before = n_out;
        step(1, 8'h01, 8'h01, 0, 0, 1);
        step(1, 8'h02, 8'h02, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 8'h03, 8'h03, 0, 0, 0);
        step(1, 8'h03, 8'h03, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 0, 0, 1);
        check("stall_count", n_out - out_before, 3);
        check("stall_queue_empty", exp_q.size(), 0);

        step(1, 8'hFF, 8'h01, 0, 0, 1);
        exp_q.delete();
        in_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("midrst_out_valid", out_valid, 0);
            check("midrst_s", S, 0);
            check("midrst_flags", {Co, ovf, zero, neg}, 0);
            cyc();
        end

        out_before = n_out;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 6; i++) step(0, 8'h00, 8'h00, 0, 0, 1);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_some_out", (n_out - out_before) > 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined adder/subtractor for the SAP-1 datapath. It replaces the fixed 8-bit combinational ripple adder.
- The carry chain is cut into SEG-bit segments with one register stage per segment. This makes wide adds meet timing at the cost of latency.
- A valid/ready handshake connects it to the controller and the accumulator/B-register path.
- Outputs carry-out, signed overflow, zero and negative flags for flag-register use.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; NSTG = WIDTH/SEG stages (latency).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts operands this cycle.
- X  input  WIDTH  operand A.
- Y  input  WIDTH  operand B.
- cin  input  1  carry-in (add mode only).
- sub  input  1  1 = subtract (X - Y), 0 = add (X + Y + cin).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result this cycle.
- S  output  WIDTH  sum/difference.
- Co  output  1  carry-out of MSB; in subtract mode 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  S == 0.
- neg  output  1  S[WIDTH-1].

Behaviour:
- Reset (rst=1 at clk edge):
  - all stage valid bits, data, carry and flag registers clear to 0.
  - out_valid=0, S=0, Co=0, ovf=0, zero=0, neg=0.
  - reset mid-operation discards every in-flight result, with no partial output.
- Effective operands:
  - B' = sub ? ~Y : Y.
  - c0 = sub ? 1 : cin.
  - cin is ignored when sub=1.
- Stage k (k = 0..NSTG-1):
  - adds X[k*SEG +: SEG] + B'[k*SEG +: SEG] + carry from stage k-1 (c0 for k=0).
  - registers its SEG sum bits and carry-out.
  - passes forward the not-yet-summed upper operand bits and the already-computed lower sum bits.
  - plain ripple inside a segment; no lookahead.
- Latency: a transaction accepted at edge t appears with out_valid=1 after edge t+NSTG-1 when there is no stall. NSTG=2 gives two register stages.
- Throughput: one transaction per cycle when out_ready is held at 1.
- Handshake:
  - global advance = ~out_valid | out_ready.
  - in_ready = advance; a transfer in occurs when in_valid & in_ready.
  - when advance=0, every stage holds, including bubbles; out_valid, S and flags stay stable until taken.
  - a bubble (in_valid=0 while advancing) propagates as a valid=0 slot.
  - in_ready does not depend combinationally on in_valid.
- Flags, computed in the final stage and registered with S:
  - Co = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|S.
  - neg = S[WIDTH-1].
- Wrap-around: with the optional feature disabled, S is modulo 2^WIDTH. Example: FF+01 gives S=00, Co=1, zero=1.
- Output values while out_valid=0 are don't-care, except after reset, where they are 0.
- Simultaneous take and accept in the same cycle is legal and loses no data.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined:
  - on signed overflow (ovf=1), S saturates: 0x7F..F if the true result is positive (X[MSB]=0), 0x80..0 if negative.
  - ovf still reports 1; Co reports the raw adder carry; zero and neg reflect the saturated S.
  - the saturation mux lives in the final stage; latency is unchanged.
- Undefined: S wraps as described above; no saturation logic is generated.

Test Plan (WIDTH=8, SEG=4, NSTG=2):
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, S=00, all flags 0; in_ready=1 after reset released.
- Add with carry chain across segment: X=0F, Y=01, cin=0, sub=0 -> 2 cycles later S=10, Co=0, ovf=0, zero=0.
- Subtract/borrow:
  - X=05, Y=07, sub=1 -> S=FE, Co=0, neg=1.
  - X=07, Y=07, sub=1 -> S=00, Co=1, zero=1.
- Overflow: X=7F, Y=01, sub=0 -> ovf=1.
  - S=80, neg=1 without ADDSUB_SAT_EN.
  - S=7F, neg=0 with ADDSUB_SAT_EN.
- Back-to-back with stall: stream 01+01, 02+02, 03+03 with out_ready=1, then drop out_ready for 3 cycles mid-stream -> results 02, 04, 06 appear in order, none lost or duplicated; in_ready=0 while stalled with out_valid=1.
- Reset mid-flight: accept X=FF, Y=01, assert rst next cycle -> no out_valid for that transaction; outputs 0.
